// File: rtl/id_inst_buffer.sv
// id_inst_buffer: IF->ID instruction FIFO pairing each fetched PC with the SRAM data returned a cycle later.
// An empty buffer bypasses the capture stage straight to decode; flush and rst both drop all contents.
module id_inst_buffer #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    output logic              fetch_ready,
    input  logic [INST_W-1:0] inst_sram_rdata,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] OCC_MAX = (CNT_W + 1)'(DEPTH);

    logic              r_s1_valid;
    logic [PC_W-1:0]   r_s1_pc;
    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_clr;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W:0]    w_occ;

    assign w_clr    = rst || flush;
    assign w_empty  = r_count == '0;
    // The in-flight pair reserves its slot, so back-pressure never depends on out_ready.
    assign w_occ    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
    assign fetch_ready = w_occ < OCC_MAX;
    assign w_accept = if_valid && fetch_ready && !flush;
    assign w_push   = r_s1_valid && !(w_empty && out_ready) && !w_clr;
    assign w_pop    = !w_empty && out_ready && !w_clr;
    assign count    = r_count;

    always_comb begin
        out_valid = !w_empty || r_s1_valid;
        out_pc    = !w_empty ? r_mem_pc[r_rd_ptr]   : r_s1_valid ? r_s1_pc         : '0;
        out_inst  = !w_empty ? r_mem_inst[r_rd_ptr] : r_s1_valid ? inst_sram_rdata : '0;
    end

    always_ff @(posedge clk) begin
        r_s1_pc <= if_pc;
        if (w_clr) begin
            r_s1_valid <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_rd_ptr   <= w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
            r_wr_ptr   <= w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
            r_count    <= (w_push && !w_pop) ? r_count + CNT_W'(1) :
                          (w_pop && !w_push) ? r_count - CNT_W'(1) : r_count;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_s1_pc;
            r_mem_inst[r_wr_ptr] <= inst_sram_rdata;
        end
    end
endmodule
